multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Sequencing controller for the multicycle RV32I datapath; successor to the single-cycle opcode decoder.
//  Steps each instruction through fetch/decode/execute/writeback states and drives the per-cycle datapath controls.
//  Adds a memory wait handshake, illegal-opcode detection with selectable trap, and a retire strobe.
//  Covers lw, sw, R-type, I-type ALU, beq and jal.
// PARAMETERS
//  WAIT_STATES_EN  1  1: hold memory states until mem_ready=1; 0: mem_ready ignored, taken as 1
//  ILLEGAL_TRAP    1  1: illegal op -> TRAP (halt until reset); 0: illegal op -> FETCH, no writes
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  op         in   7  opcode field of the instruction register
//  mem_ready  in   1  unified memory access complete this cycle
//  mem_req    out  1  memory access request
//  AdrSrc     out  1  memory address select: 0=PC, 1=Result
//  IRWrite    out  1  instruction register load
//  PCUpdate   out  1  unconditional PC load
//  Branch     out  1  conditional PC load (ANDed with Zero outside)
//  RegWrite   out  1  register file write
//  MemWrite   out  1  data memory write
//  ALUSrcA    out  2  00=PC, 01=OldPC, 10=RD1
//  ALUSrcB    out  2  00=RD2, 01=ImmExt, 10=const 4
//  ALUOp      out  2  00=add, 01=sub/compare, 10=funct-decoded
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc     out  2  00=I, 01=S, 10=B, 11=J
//  instr_done out  1  one-cycle retire pulse
//  illegal    out  1  sticky illegal-opcode flag
// BEHAVIOUR
//  - Decided interface: one clock; reset is asynchronous and active-high.
//  - rst=1: state<=FETCH, illegal<=0. While rst is high, mem_req, IRWrite, PCUpdate, Branch, RegWrite, MemWrite and instr_done are forced to 0.
//  - Reset mid-instruction abandons the instruction; no write strobe is asserted after the rst edge.
//  - Controls are Moore decodes of state. Unlisted controls are 0.
//  - Exception: strobes marked "&rdy" are ANDed with effective mem_ready.
//  - ImmSrc is combinational from op in all states: 0100011->01, 1100011->10, 1101111->11, else 00.
//  - FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite&rdy, PCUpdate&rdy.
//    Goes to DECODE if rdy, else stays.
//  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//    1100011 -> BEQ; 1101111 -> JAL; any other op -> illegal.
//  - Illegal op: illegal<=1. Next state is TRAP if ILLEGAL_TRAP=1, else FETCH.
//  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
//  - MEMREAD: mem_req, AdrSrc=1, ResultSrc=00. Goes to MEMWB on rdy, else holds.
//  - MEMWRITE: mem_req, AdrSrc=1, ResultSrc=00, MemWrite&rdy, instr_done&rdy. Goes to FETCH on rdy, else holds.
//  - MEMWB: ResultSrc=01, RegWrite, instr_done -> FETCH.
//  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
//  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite, instr_done -> FETCH.
//  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch, instr_done -> FETCH.
//  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate -> ALUWB (writes rd=PC+4).
//  - TRAP: all strobes 0; holds until reset.
//  - Cycle counts with zero wait states: lw 5, sw 4, R/I 4, beq 3, jal 4.
//    Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
//  - instr_done never asserts for an illegal instruction. illegal is cleared only by rst.
//  - mem_ready high outside memory states has no effect.
// TESTING
//  - Reset: rst pulsed mid-MEMWRITE with mem_ready=0 -> MemWrite=0 immediately; after release FETCH, illegal=0.
//  - R-type: op=0110011, mem_ready=1 -> 4 cycles, RegWrite+instr_done in cycle 4 only, ALUOp=10 in EXECUTER.
//  - lw with waits: op=0000011, mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total, IRWrite exactly once.
//  - beq/jal: beq -> Branch=1 for one cycle in cycle 3; jal -> PCUpdate in FETCH and JAL, RegWrite in cycle 4, ImmSrc=11.
//  - Illegal: op=1111111 with ILLEGAL_TRAP=1 -> illegal=1 and stuck in TRAP with no strobes; with ILLEGAL_TRAP=0 -> next fetch proceeds, illegal stays 1.
//  - WAIT_STATES_EN=0: mem_ready tied 0 -> sw completes in 4 cycles, MemWrite=1 in cycle 4.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: walks each instruction through fetch/decode/execute/writeback and drives datapath controls.
// Memory states stall on mem_ready; an illegal opcode either traps until reset or is dropped back to fetch.
module multicycle_control_unit #(
  parameter bit WAIT_STATES_EN = 1'b1,
  parameter bit ILLEGAL_TRAP   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_rdy;
  logic   w_op_bad;

  assign w_rdy   = WAIT_STATES_EN ? mem_ready : 1'b1;
  assign illegal = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_op_bad)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    w_op_bad   = 1'b0;
    w_next     = r_state;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ResultSrc  = 2'b00;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_rdy;
        PCUpdate  = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BEQ;
          7'b1101111:             w_next = S_JAL;
          default: begin
            w_op_bad = 1'b1;
            w_next   = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        MemWrite   = w_rdy;
        instr_done = w_rdy;
        if (w_rdy) w_next = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      // Link value PC+4 is computed here and written back through ALUWB.
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        w_next   = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    // Strobes are suppressed for the whole reset pulse, not just after the edge.
    if (rst) begin
      mem_req    = 1'b0;
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: three instances (default, fetch-on-illegal, no wait states).
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [6:0] op;
  logic       rdy;

  logic       mem_req    [3];
  logic       adrsrc     [3];
  logic       irwrite    [3];
  logic       pcupdate   [3];
  logic       branch     [3];
  logic       regwrite   [3];
  logic       memwrite   [3];
  logic [1:0] alusrca    [3];
  logic [1:0] alusrcb    [3];
  logic [1:0] aluop      [3];
  logic [1:0] resultsrc  [3];
  logic [1:0] immsrc     [3];
  logic       instr_done [3];
  logic       illegal    [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: illegal op returns to fetch, 2: mem_ready ignored
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control_unit #(
      .WAIT_STATES_EN(g != 2),
      .ILLEGAL_TRAP  (g != 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_v[g]),
      .op        (op),
      .mem_ready (rdy),
      .mem_req   (mem_req[g]),
      .AdrSrc    (adrsrc[g]),
      .IRWrite   (irwrite[g]),
      .PCUpdate  (pcupdate[g]),
      .Branch    (branch[g]),
      .RegWrite  (regwrite[g]),
      .MemWrite  (memwrite[g]),
      .ALUSrcA   (alusrca[g]),
      .ALUSrcB   (alusrcb[g]),
      .ALUOp     (aluop[g]),
      .ResultSrc (resultsrc[g]),
      .ImmSrc    (immsrc[g]),
      .instr_done(instr_done[g]),
      .illegal   (illegal[g])
    );
  end

  // {mem_req,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,instr_done, AdrSrc, A, B, ALUOp, Result, Imm, illegal}
  function automatic logic [18:0] mk(input logic [6:0] s, input logic a, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] ao, input logic [1:0] rs,
                                     input logic [1:0] im, input logic il);
    return {s, a, sa, sb, ao, rs, im, il};
  endfunction

  function automatic logic [6:0] strb(input int k);
    return {mem_req[k], irwrite[k], pcupdate[k], branch[k], regwrite[k], memwrite[k], instr_done[k]};
  endfunction

  function automatic logic [18:0] outv(input int k);
    return {strb(k), adrsrc[k], alusrca[k], alusrcb[k], aluop[k], resultsrc[k], immsrc[k], illegal[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] mask);
    rst_v = mask;
    @(posedge clk);
    #1;
    rst_v = 3'b000;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [22];
  logic sched [10];
  int   done_cyc;
  int   ir_cnt;

  initial begin
    tbl[0]  = '{OP_R,   1'b0, mk(7'b1000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0)};
    tbl[1]  = '{OP_R,   1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0)};
    tbl[2]  = '{OP_R,   1'b0, mk(7'b0000000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[3]  = '{OP_R,   1'b1, mk(7'b0000000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0)};
    tbl[4]  = '{OP_R,   1'b0, mk(7'b0000101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[5]  = '{OP_I,   1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0)};
    tbl[6]  = '{OP_I,   1'b1, mk(7'b0000000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[7]  = '{OP_I,   1'b0, mk(7'b0000000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0)};
    tbl[8]  = '{OP_I,   1'b1, mk(7'b0000101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)};
    tbl[9]  = '{OP_BEQ, 1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0)};
    tbl[10] = '{OP_BEQ, 1'b1, mk(7'b0000000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0)};
    tbl[11] = '{OP_BEQ, 1'b0, mk(7'b0001001, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0)};
    tbl[12] = '{OP_JAL, 1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 1'b0)};
    tbl[13] = '{OP_JAL, 1'b1, mk(7'b0000000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 1'b0)};
    tbl[14] = '{OP_JAL, 1'b1, mk(7'b0010000, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0)};
    tbl[15] = '{OP_JAL, 1'b1, mk(7'b0000101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0)};
    tbl[16] = '{OP_SW,  1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0)};
    tbl[17] = '{OP_SW,  1'b1, mk(7'b0000000, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0)};
    tbl[18] = '{OP_SW,  1'b1, mk(7'b0000000, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0)};
    tbl[19] = '{OP_SW,  1'b0, mk(7'b1000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)};
    tbl[20] = '{OP_SW,  1'b1, mk(7'b1000011, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0)};
    tbl[21] = '{OP_R,   1'b1, mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0)};

    // reset state: strobes held low while rst is high, even with mem_ready=1
    rst_v = 3'b111;
    op    = OP_R;
    rdy   = 1'b1;
    #12;
    chk("reset_outputs", outv(0), mk(7'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    @(posedge clk);
    #1;
    rst_v = 3'b000;

    for (int i = 0; i < 22; i++) begin
      op  = tbl[i].op;
      rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outv(0), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // lw: 2 stall cycles in FETCH, 3 in MEMREAD -> 10 cycles total
    do_reset(3'b111);
    sched    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    done_cyc = 0;
    ir_cnt   = 0;
    op       = OP_LW;
    for (int c = 0; c < 30; c++) begin
      rdy = (c < 10) ? sched[c] : 1'b1;
      @(negedge clk);
      if (irwrite[0]) ir_cnt++;
      if (c == 5) chk("lw_memread", outv(0), mk(7'b1000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      if (instr_done[0]) begin
        done_cyc = c + 1;
        chk("lw_memwb", outv(0), mk(7'b0000101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
      end
      @(posedge clk);
      #1;
      if (done_cyc != 0) break;
    end
    chk("lw_cycles", done_cyc, 10);
    chk("lw_irwrite_count", ir_cnt, 1);

    // illegal opcode: instance 0 traps, instance 1 goes on to fetch and retire an R-type
    do_reset(3'b111);
    op  = OP_BAD;
    rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) op = OP_R;
      @(negedge clk);
      if (c == 1) chk("ill_decode", outv(0), mk(7'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
      if (c >= 2) chk($sformatf("trap_c%0d", c), outv(0), mk(7'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
      if (c == 2) chk("nt_refetch", outv(1), mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1));
      if (c == 5) chk("nt_retire", outv(1), mk(7'b0000101, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
      @(posedge clk);
      #1;
    end

    // no wait states: sw with mem_ready tied low still completes in 4 cycles
    do_reset(3'b101);
    op       = OP_SW;
    rdy      = 1'b0;
    done_cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_done[2]) begin
        done_cyc = c + 1;
        chk("nw_memwrite", memwrite[2], 1);
      end
      @(posedge clk);
      #1;
      if (done_cyc != 0) break;
    end
    chk("nw_cycles", done_cyc, 4);
    @(negedge clk);
    chk("stall_fetch", outv(0), mk(7'b1000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0));
    @(posedge clk);
    #1;

    // reset in the middle of a stalled MEMWRITE
    rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("mw_stalled", outv(0), mk(7'b1000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
    chk("illegal_sticky", illegal[1], 1);
    rdy   = 1'b1;
    rst_v = 3'b111;
    #1;
    chk("rst_async_strobes", strb(0), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_strobes", strb(0), 0);
    rst_v = 3'b000;
    op    = OP_R;
    @(negedge clk);
    chk("rst_fetch", outv(0), mk(7'b1110000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    chk("rst_clears_illegal", illegal[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
